instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Producer side of the 72-bit instruction path: owns the program counter, issues word reads to instruction memory, and delivers fetched 72-bit instructions with their PC to decode through a valid/ready handshake. Sits between the instruction memory and the processor top, which consumes `Instruction_Fetch` and drives `Branch_en` / `Jump_en` back as redirects. Credit-based buffering lets it absorb variable memory latency and decode stalls without losing or duplicating instructions.

## Interface
- `ADDR_W`, 16, PC / instruction-memory word-address width.
- `INSTR_W`, 72, instruction width.
- `RESET_PC`, 0, first fetch address after reset.
- `DEPTH`, 4, output FIFO entries; also the max of in-flight requests plus buffered instructions. Power of two, ≥2.
- Reset is asynchronous and active-low; one clock.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-low reset.
- `Branch_en` in 1: taken-branch redirect.
- `Jump_en` in 1: jump redirect.
- `target_addr` in ADDR_W: redirect target, sampled when `Branch_en|Jump_en`.
- `stall` in 1: suppresses new memory requests.
- `imem_req_valid` out 1: read request.
- `imem_req_addr` out ADDR_W: read address (= PC).
- `imem_req_ready` in 1: memory accepts request.
- `imem_rsp_valid` in 1: read data valid. In order, one per accepted request, no backpressure.
- `imem_rsp_data` in INSTR_W: read data.
- `Instruction_Fetch` out INSTR_W: FIFO head instruction.
- `instr_pc` out ADDR_W: PC of head instruction.
- `instr_valid` out 1: head valid.
- `instr_ready` in 1: decode accepts head.

## Operation
- States:
  - BOOT: first cycle after reset release, no requests; → RUN.
  - RUN: fetching.
  - FLUSH: discarding stale responses, no requests.
- `redirect = Branch_en | Jump_en`. Both use `target_addr`; they are not distinguished.
- `inflight` counter range 0..DEPTH; `count` = FIFO occupancy.
- Credit: a request may issue only when `inflight + count < DEPTH`. The FIFO can therefore never overflow.
- `imem_req_valid = (state==RUN) & ~stall & ~redirect & credit`. `imem_req_addr = pc`.
- Request accept (`imem_req_valid & imem_req_ready`): pc ← pc+1, wrapping modulo 2^ADDR_W; inflight+1.
- Response in RUN: write {data, pc-tag} to FIFO; inflight−1. The PC tag comes from an internal tag queue or counter that matches the response order.
- Pop on `instr_valid & instr_ready`. Simultaneous push and pop keeps `count` unchanged.
- Redirect at cycle N, in any state:
  - pc ← `target_addr`.
  - FIFO cleared. A pop completing in cycle N counts as accepted.
  - `drop_cnt ← inflight − imem_rsp_valid`, and inflight is set to the same value.
  - Next state is FLUSH if that value is nonzero, otherwise RUN.
- FLUSH: each `imem_rsp_valid` is discarded and decrements `drop_cnt` and `inflight`; when it reaches 0 → RUN.
  - A redirect in FLUSH reloads pc only; the drop count still tracks the outstanding responses.
- Redirect in BOOT: pc ← target, → RUN.
- `stall` affects requests only; responses, FIFO and output handshake continue.
- `rst` low at any time, including mid-flush or with requests outstanding: all state returns to reset immediately.
  - The memory must also be reset; stale responses after reset are not supported.

## Timing
- Reset values:
  - pc=RESET_PC, state=BOOT, inflight=0, count=0, drop_cnt=0.
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `instr_valid`=0, `Instruction_Fetch`=0, `instr_pc`=0.
- The first request is possible in cycle 2 after `rst` rises: BOOT occupies cycle 1.
- For a request accepted in cycle t with response in t+L: `instr_valid` asserts in t+L+1 (registered FIFO).
- Redirect in N, with no in-flight requests and L=1:
  - request at `target_addr` in N+1.
  - response in N+2.
  - `instr_valid` in N+3.
- `instr_valid` is 0 from N+1 until the first post-redirect instruction lands.
- Full throughput (one instruction per cycle) requires DEPTH ≥ L+1 and `instr_ready` held high.
- `Instruction_Fetch` / `instr_pc` stay stable while `instr_valid & ~instr_ready`.

## Test plan
- Reset with RESET_PC=0x0010, memory L=1 with data=addr, `instr_ready`=1:
  - `instr_pc` sequence is 0x10, 0x11, 0x12… with one instruction per cycle after fill.
  - No gaps or duplicates.
- `instr_ready`=0 for 10 cycles with DEPTH=4:
  - At most 4 requests are accepted.
  - `imem_req_valid` drops to 0.
  - On release, the FIFO drains 0x10..0x13 in order.
- Jump to 0x0200 with memory L=3 and 3 requests in flight:
  - 3 responses are discarded.
  - Next delivered `instr_pc`=0x0200.
  - No pre-jump instruction is delivered after N.
- Branch_en and Jump_en asserted together with target 0x0040, plus a second redirect to 0x0080 during FLUSH:
  - The first delivered instruction is 0x0080.
- PC=0xFFFF with ADDR_W=16:
  - The next request is 0x0000.
  - Assert `stall` for 5 cycles: no requests are accepted, and buffered instructions still drain.
- Assert `rst` low mid-FLUSH with inflight=2:
  - All outputs go to reset values immediately.
  - After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Producer side of the 72-bit instruction path. Owns the program counter,
// issues one-word reads to instruction memory and hands fetched instructions,
// tagged with their PC, to decode over a valid/ready handshake.
//
// Handshake semantics (all interfaces): a transfer happens on a rising clock
// edge where valid and ready are both high; valid never depends on ready.
// The memory response channel has no ready: every imem_rsp_valid is a transfer.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   Branch_en, Jump_en redirect requests (treated identically)
//   target_addr        redirect target, sampled while either redirect is high
//   stall              holds off new memory requests only
//   imem_req_*         read request channel (valid/ready, addr = pc)
//   imem_rsp_*         in-order read data, one beat per accepted request
//   Instruction_Fetch  head-of-FIFO instruction (0 while instr_valid is low)
//   instr_pc           PC of the head instruction (0 while instr_valid is low)
//   instr_valid/ready  decode handshake
//   fsm_state          current controller state (BOOT=0, RUN=1, FLUSH=2)
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 72,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Branch_en,
    input  logic               Jump_en,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic               stall,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [INSTR_W-1:0] Instruction_Fetch,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [1:0]         fsm_state
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic              redirect;
    logic              credit;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  drop_val;
    logic [ADDR_W-1:0] rsp_pc;

    assign redirect  = Branch_en | Jump_en;
    // In-flight requests plus buffered instructions never exceed DEPTH, so a
    // response always finds a free FIFO slot.
    assign occupancy = {1'b0, inflight} + {1'b0, count};
    assign credit    = occupancy < (CNT_W + 1)'(DEPTH);

    assign imem_req_valid = (state == RUN) & ~stall & ~redirect & credit;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign instr_valid       = (count != '0);
    assign Instruction_Fetch = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc          = instr_valid ? pc_mem[rd_ptr]   : '0;
    assign pop               = instr_valid & instr_ready;

    // A response arriving in the redirect cycle is already stale, so it is
    // neither buffered nor carried into the drop count.
    assign push     = (state == RUN) & imem_rsp_valid & ~redirect;
    assign drop_val = inflight - CNT_W'(imem_rsp_valid);

    // Responses return in request order and RUN is only entered with nothing
    // stale outstanding, so the oldest outstanding request was issued at
    // pc - inflight. This replaces a separate tag queue.
    assign rsp_pc = pc - ADDR_W'(inflight);

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                if (redirect) begin
                    next_state = (drop_val != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    next_state = (drop_val != '0) ? FLUSH : RUN;
                end else if (imem_rsp_valid && (drop_cnt == CNT_W'(1))) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (redirect) begin
                pc <= target_addr;
            end else if (req_fire) begin
                pc <= pc + ADDR_W'(1);
            end

            if (redirect) begin
                // Any pop in this cycle is honoured by decode; the rest of
                // the buffer is stale and simply forgotten.
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                if (state != BOOT) begin
                    inflight <= drop_val;
                    drop_cnt <= drop_val;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);

                if (state == FLUSH) begin
                    if (imem_rsp_valid) begin
                        inflight <= inflight - CNT_W'(1);
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end
                end else if (state == RUN) begin
                    inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          ADDR_W  = 16;
  localparam int          INSTR_W = 72;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] RST_PC  = 16'h0010;
  localparam logic [1:0]  S_BOOT  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_FLUSH = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               Branch_en = 1'b0;
  logic               Jump_en = 1'b0;
  logic [ADDR_W-1:0]  target_addr = '0;
  logic               stall = 1'b0;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready = 1'b0;
  logic               imem_rsp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_rsp_data = '0;
  logic [INSTR_W-1:0] Instruction_Fetch;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [1:0]         fsm_state;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .Branch_en(Branch_en), .Jump_en(Jump_en),
    .target_addr(target_addr), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .Instruction_Fetch(Instruction_Fetch),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fsm_state(fsm_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- memory model and transfer logs ----------------
  int          mem_lat = 1;
  int          edge_cnt = 0;
  int          rel_edge = 0;
  logic [15:0] pend_addr[$];
  int          pend_due[$];
  logic [15:0] acc_addr[$];
  int          acc_edge[$];
  logic [15:0] deliv_pc[$];
  logic [71:0] deliv_data[$];
  int          deliv_edge[$];

  function automatic logic [71:0] mem_data(input logic [15:0] a);
    return {a ^ 16'hBEEF, 40'hC0_FFEE_1234, a};
  endfunction

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(edge_cnt + mem_lat);
        acc_addr.push_back(imem_req_addr);
        acc_edge.push_back(edge_cnt);
      end
      if (instr_valid && instr_ready) begin
        deliv_pc.push_back(instr_pc);
        deliv_data.push_back(Instruction_Fetch);
        deliv_edge.push_back(edge_cnt);
      end
    end
  end

  // Responses are driven for the cycle ending at the due edge.
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst && pend_due.size() > 0) begin
      if (pend_due[0] == edge_cnt + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic assert_reset(input int lat, input logic irdy, input logic rrdy);
    @(negedge clk);
    rst = 1'b0;
    Branch_en = 1'b0;
    Jump_en = 1'b0;
    target_addr = '0;
    stall = 1'b0;
    instr_ready = irdy;
    imem_req_ready = rrdy;
    mem_lat = lat;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    acc_addr.delete();
    acc_edge.delete();
    deliv_pc.delete();
    deliv_data.delete();
    deliv_edge.delete();
    rst = 1'b1;
    rel_edge = edge_cnt;
  endtask

  // Three requests accepted at edges 2..4 with L=3, redirect presented for edge 5.
  task automatic three_in_flight(input logic br, input logic jp, input logic [15:0] tgt);
    @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (acc_addr.size() != 3) begin
      tests_failed++;
      $display("FAIL inflight_setup: accepted %0d required 3", acc_addr.size());
    end
    imem_req_ready = 1'b0;
    Branch_en = br;
    Jump_en = jp;
    target_addr = tgt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset(1, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
    tests_run++;
    if (imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL rst_req_addr: got %h required %h", imem_req_addr, RST_PC); end
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_instr_valid: got %b required 0", instr_valid); end
    tests_run++;
    if (Instruction_Fetch !== 72'h0) begin tests_failed++; $display("FAIL rst_instr: got %h required 0", Instruction_Fetch); end
    tests_run++;
    if (instr_pc !== 16'h0) begin tests_failed++; $display("FAIL rst_instr_pc: got %h required 0", instr_pc); end
    tests_run++;
    if (fsm_state !== S_BOOT) begin tests_failed++; $display("FAIL rst_state: got %0d required %0d", fsm_state, S_BOOT); end
    release_reset();
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL boot_no_req: got %b required 0", imem_req_valid); end
    @(negedge clk);
    #1;
    tests_run++;
    if (fsm_state !== S_RUN) begin tests_failed++; $display("FAIL boot_to_run: got %0d required %0d", fsm_state, S_RUN); end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL first_req: got valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    assert_reset(1, 1'b1, 1'b1);
    release_reset();
    repeat (20) @(negedge clk);
    tests_run++;
    if (acc_edge.size() < 1 || acc_edge[0] != rel_edge + 2) begin
      tests_failed++;
      $display("FAIL stream_first_accept: got %0d accepts required first at edge %0d", acc_edge.size(), rel_edge + 2);
    end
    tests_run++;
    if (deliv_pc.size() < 12) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d deliveries required at least 12", deliv_pc.size());
    end else begin
      tests_run++;
      if (deliv_edge[0] != rel_edge + 4) begin
        tests_failed++;
        $display("FAIL stream_latency: got edge %0d required %0d", deliv_edge[0] - rel_edge, 4);
      end
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (deliv_pc[i] !== RST_PC + 16'(i) || deliv_data[i] !== mem_data(RST_PC + 16'(i))
            || deliv_edge[i] != deliv_edge[0] + i) begin
          tests_failed++;
          $display("FAIL stream_item%0d: got pc=%h data=%h edge=+%0d required pc=%h data=%h edge=+%0d",
                   i, deliv_pc[i], deliv_data[i], deliv_edge[i] - deliv_edge[0],
                   RST_PC + 16'(i), mem_data(RST_PC + 16'(i)), i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    assert_reset(1, 1'b0, 1'b1);
    release_reset();
    repeat (6) @(negedge clk);
    #1;
    tests_run++;
    if (instr_pc !== RST_PC || Instruction_Fetch !== mem_data(RST_PC)) begin
      tests_failed++;
      $display("FAIL bp_head_early: got pc=%h required %h", instr_pc, RST_PC);
    end
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (acc_addr.size() != 4) begin tests_failed++; $display("FAIL bp_accepts: got %0d required 4", acc_addr.size()); end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_valid: got %b required 0", imem_req_valid); end
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== RST_PC || Instruction_Fetch !== mem_data(RST_PC)) begin
      tests_failed++;
      $display("FAIL bp_head_hold: got valid=%b pc=%h required valid=1 pc=%h", instr_valid, instr_pc, RST_PC);
    end
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (deliv_pc.size() < 4) begin
      tests_failed++;
      $display("FAIL bp_drain_count: got %0d required at least 4", deliv_pc.size());
    end else begin
      tests_run++;
      if (deliv_edge[0] != rel_edge + 11) begin
        tests_failed++;
        $display("FAIL bp_release_edge: got %0d required %0d", deliv_edge[0] - rel_edge, 11);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (deliv_pc[i] !== RST_PC + 16'(i)) begin
          tests_failed++;
          $display("FAIL bp_drain%0d: got %h required %h", i, deliv_pc[i], RST_PC + 16'(i));
        end
      end
    end
  endtask

  task automatic test_jump_flush();
    assert_reset(3, 1'b1, 1'b0);
    release_reset();
    three_in_flight(1'b0, 1'b1, 16'h0200);
    @(negedge clk);
    Jump_en = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (fsm_state !== S_FLUSH || imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL jump_flush_enter: got state=%0d req=%b required state=%0d req=0", fsm_state, imem_req_valid, S_FLUSH);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (fsm_state !== S_FLUSH) begin tests_failed++; $display("FAIL jump_flush_hold: got %0d required %0d", fsm_state, S_FLUSH); end
    @(negedge clk);
    #1;
    tests_run++;
    if (fsm_state !== S_RUN || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0200 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL jump_resume: got state=%0d req=%b addr=%h ivalid=%b required state=%0d req=1 addr=0200 ivalid=0",
               fsm_state, imem_req_valid, imem_req_addr, instr_valid, S_RUN);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (deliv_pc.size() < 3) begin
      tests_failed++;
      $display("FAIL jump_deliv_count: got %0d required at least 3", deliv_pc.size());
    end else begin
      tests_run++;
      if (deliv_edge[0] != rel_edge + 12) begin
        tests_failed++;
        $display("FAIL jump_first_edge: got %0d required %0d", deliv_edge[0] - rel_edge, 12);
      end
      for (int i = 0; i < deliv_pc.size(); i++) begin
        tests_run++;
        if (deliv_pc[i] !== 16'h0200 + 16'(i) || deliv_data[i] !== mem_data(16'h0200 + 16'(i))) begin
          tests_failed++;
          $display("FAIL jump_deliv%0d: got %h required %h", i, deliv_pc[i], 16'h0200 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_double_redirect();
    assert_reset(3, 1'b1, 1'b0);
    release_reset();
    three_in_flight(1'b1, 1'b1, 16'h0040);
    @(negedge clk);
    Jump_en = 1'b0;
    Branch_en = 1'b1;
    target_addr = 16'h0080;
    #1;
    tests_run++;
    if (fsm_state !== S_FLUSH) begin tests_failed++; $display("FAIL dual_flush: got %0d required %0d", fsm_state, S_FLUSH); end
    @(negedge clk);
    Branch_en = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (fsm_state !== S_FLUSH) begin tests_failed++; $display("FAIL dual_flush2: got %0d required %0d", fsm_state, S_FLUSH); end
    @(negedge clk);
    #1;
    tests_run++;
    if (fsm_state !== S_RUN || imem_req_addr !== 16'h0080) begin
      tests_failed++;
      $display("FAIL dual_resume: got state=%0d addr=%h required state=%0d addr=0080", fsm_state, imem_req_addr, S_RUN);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (deliv_pc.size() < 1) begin
      tests_failed++;
      $display("FAIL dual_deliv_count: got 0 required at least 1");
    end else begin
      for (int i = 0; i < deliv_pc.size(); i++) begin
        tests_run++;
        if (deliv_pc[i] !== 16'h0080 + 16'(i)) begin
          tests_failed++;
          $display("FAIL dual_deliv%0d: got %h required %h", i, deliv_pc[i], 16'h0080 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_wrap_stall();
    int a0;
    assert_reset(1, 1'b0, 1'b0);
    release_reset();
    repeat (2) @(negedge clk);
    Jump_en = 1'b1;
    target_addr = 16'hFFFE;
    @(negedge clk);
    Jump_en = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (fsm_state !== S_RUN || imem_req_addr !== 16'hFFFE) begin
      tests_failed++;
      $display("FAIL wrap_redirect: got state=%0d addr=%h required state=%0d addr=fffe", fsm_state, imem_req_addr, S_RUN);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (acc_addr.size() != 4) begin
      tests_failed++;
      $display("FAIL wrap_accepts: got %0d required 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (acc_addr[i] !== 16'hFFFE + 16'(i)) begin
          tests_failed++;
          $display("FAIL wrap_addr%0d: got %h required %h", i, acc_addr[i], 16'hFFFE + 16'(i));
        end
      end
    end
    a0 = acc_addr.size();
    stall = 1'b1;
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid: got %b required 0", imem_req_valid); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (acc_addr.size() != a0) begin tests_failed++; $display("FAIL stall_accepts: got %0d required %0d", acc_addr.size(), a0); end
    tests_run++;
    if (deliv_pc.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_drain: got %0d required 4", deliv_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (deliv_pc[i] !== 16'hFFFE + 16'(i)) begin
          tests_failed++;
          $display("FAIL stall_deliv%0d: got %h required %h", i, deliv_pc[i], 16'hFFFE + 16'(i));
        end
      end
    end
    stall = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (acc_addr.size() <= a0 || acc_addr[a0] !== 16'h0002) begin
      tests_failed++;
      $display("FAIL unstall_addr: got %0d accepts required next addr 0002", acc_addr.size());
    end
  endtask

  task automatic test_reset_mid_flush();
    assert_reset(3, 1'b1, 1'b0);
    release_reset();
    three_in_flight(1'b0, 1'b1, 16'h0200);
    @(negedge clk);
    #1;
    tests_run++;
    if (fsm_state !== S_FLUSH) begin tests_failed++; $display("FAIL mid_flush_state: got %0d required %0d", fsm_state, S_FLUSH); end
    rst = 1'b0;
    Jump_en = 1'b0;
    #1;
    tests_run++;
    if (fsm_state !== S_BOOT || imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC ||
        instr_valid !== 1'b0 || Instruction_Fetch !== 72'h0 || instr_pc !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_flush_reset: got state=%0d req=%b addr=%h iv=%b pc=%h required state=0 req=0 addr=%h iv=0 pc=0",
               fsm_state, imem_req_valid, imem_req_addr, instr_valid, instr_pc, RST_PC);
    end
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b1;
    release_reset();
    repeat (8) @(negedge clk);
    tests_run++;
    if (acc_addr.size() < 1 || acc_addr[0] !== RST_PC || acc_edge[0] != rel_edge + 2) begin
      tests_failed++;
      $display("FAIL restart_req: got %0d accepts required first %h at edge 2", acc_addr.size(), RST_PC);
    end
    tests_run++;
    if (deliv_pc.size() < 1 || deliv_pc[0] !== RST_PC) begin
      tests_failed++;
      $display("FAIL restart_deliv: got %0d deliveries required first %h", deliv_pc.size(), RST_PC);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_flush();
    test_double_redirect();
    test_wrap_stall();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
